// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA/DVI raster timing generator running entirely on the system
// clock. An integer clock-enable divider produces pix_en once every CLK_DIV
// clocks; the horizontal/vertical counters advance only on those edges.
//
// Optional feature macro: VGA_FRAME_COUNT_EN
//   When defined, adds a 16-bit wrapping frame counter output (frame_count)
//   that increments on the same edge that asserts frame_start.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   enable       in   run; 0 freezes divider, counters and all outputs
//   pix_en       out  one-clock pulse per pixel period
//   hsync        out  horizontal sync, active level HSYNC_POL
//   vsync        out  vertical sync, active level VSYNC_POL
//   de           out  1 only inside the active area
//   pixel_x      out  horizontal count, 0..H_TOTAL-1
//   pixel_y      out  vertical count, 0..V_TOTAL-1
//   line_start   out  one-clock pulse when pixel_x becomes 0
//   frame_start  out  one-clock pulse when pixel_x and pixel_y become 0
//   frame_count  out  (VGA_FRAME_COUNT_EN only) frames started since reset
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CW        = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic          HS_ON    = (HSYNC_POL != 0);
    localparam logic          VS_ON    = (VSYNC_POL != 0);

    logic [DW-1:0] div;
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;

    // pix_en is combinational so that it coincides with the edge that
    // advances the counters; gating with reset keeps it at 0 while reset is
    // held even when CLK_DIV=1 (divider permanently at its last value).
    always_comb begin
        pix_en = enable & ~reset & (div == DIV_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (enable) begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    // Next raster position; equals the current one when no pixel edge.
    always_comb begin
        x_nxt = pixel_x;
        y_nxt = pixel_y;
        if (pix_en) begin
            if (pixel_x == X_LAST) begin
                x_nxt = '0;
                y_nxt = (pixel_y == Y_LAST) ? '0 : pixel_y + 1'b1;
            end else begin
                x_nxt = pixel_x + 1'b1;
            end
        end
    end

    // Sync/de/strobes are decoded from the next position so they load on the
    // same edge as the counters and stay aligned with pixel_x/pixel_y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= x_nxt;
            pixel_y     <= y_nxt;
            hsync       <= ((x_nxt >= HS_BEG) && (x_nxt < HS_END)) ? HS_ON : ~HS_ON;
            vsync       <= ((y_nxt >= VS_BEG) && (y_nxt < VS_END)) ? VS_ON : ~VS_ON;
            de          <= (x_nxt < X_ACT) && (y_nxt < Y_ACT);
            line_start  <= pix_en && (x_nxt == '0);
            frame_start <= pix_en && (x_nxt == '0) && (y_nxt == '0);
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (pix_en && (x_nxt == '0) && (y_nxt == '0)) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule
